// File: rtl/resp_cancel_tracker.sv
// In-order tracker for outstanding cache requests: marks entries cancelled on flush and drops their late responses.
// Optional TRACKER_STATS_EN adds drop_cnt (saturating dropped-response count) and max_outstanding (occupancy high-water mark).
module resp_cancel_tracker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_accept,
    input  logic             req_keep,
    input  logic             resp_ok,
    input  logic             flush_hard,
    input  logic             flush_soft,
    output logic             issue_allow,
    output logic             resp_valid,
    output logic             resp_drop,
    output logic [CNT_W-1:0] outstanding,
    output logic             empty,
    output logic             proto_err
`ifdef TRACKER_STATS_EN
    ,
    output logic [31:0]      drop_cnt,
    output logic [CNT_W-1:0] max_outstanding
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0] cancel_q, cancel_d;
    logic [DEPTH-1:0] keep_q, keep_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             proto_err_q, proto_err_d;

    logic is_full;
    logic is_empty;
    logic do_pop;
    logic do_push;
    logic head_cancel;
    logic push_cancel;

    always_comb begin
        is_full     = (count_q == CNT_FULL);
        is_empty    = (count_q == '0);
        do_pop      = resp_ok && !is_empty;
        // A pop in the same cycle frees a slot, so a push into a full tracker is legal then.
        do_push     = req_accept && (!is_full || do_pop);
        head_cancel = cancel_q[rd_ptr_q] | flush_hard | (flush_soft & ~keep_q[rd_ptr_q]);
        push_cancel = flush_hard | (flush_soft & ~req_keep);
        issue_allow = !is_full || resp_ok;
        resp_valid  = do_pop && !head_cancel && !reset;
        resp_drop   = do_pop && head_cancel && !reset;
    end

    always_comb begin
        // Flushes apply to every slot; stale slots are rewritten on push anyway.
        cancel_d = cancel_q | {DEPTH{flush_hard}} | ({DEPTH{flush_soft}} & ~keep_q);
        keep_d   = keep_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            cancel_d[wr_ptr_q] = push_cancel;
            keep_d[wr_ptr_q]   = req_keep;
            wr_ptr_d           = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        empty_d     = (count_d == '0);
        proto_err_d = proto_err_q
                    | (req_accept && is_full && !resp_ok)
                    | (resp_ok && is_empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cancel_q    <= '0;
            keep_q      <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            proto_err_q <= 1'b0;
        end else begin
            cancel_q    <= cancel_d;
            keep_q      <= keep_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign outstanding = count_q;
    assign empty       = empty_q;
    assign proto_err   = proto_err_q;

`ifdef TRACKER_STATS_EN
    logic [31:0]      drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] max_q, max_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (resp_drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
        max_d = (count_d > max_q) ? count_d : max_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
            max_q      <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            max_q      <= max_d;
        end
    end

    assign drop_cnt        = drop_cnt_q;
    assign max_outstanding = max_q;
`endif

endmodule

// File: tb/tb_resp_cancel_tracker.sv
// Randomised plus directed bench for resp_cancel_tracker against a queue-based reference model.
module tb_resp_cancel_tracker;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             req_accept, req_keep, resp_ok, flush_hard, flush_soft;
    logic             issue_allow, resp_valid, resp_drop, empty, proto_err;
    logic [CNT_W-1:0] outstanding;
`ifdef TRACKER_STATS_EN
    logic [31:0]      drop_cnt;
    logic [CNT_W-1:0] max_outstanding;
`endif

    resp_cancel_tracker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_accept  (req_accept),
        .req_keep    (req_keep),
        .resp_ok     (resp_ok),
        .flush_hard  (flush_hard),
        .flush_soft  (flush_soft),
        .issue_allow (issue_allow),
        .resp_valid  (resp_valid),
        .resp_drop   (resp_drop),
        .outstanding (outstanding),
        .empty       (empty),
        .proto_err   (proto_err)
`ifdef TRACKER_STATS_EN
        ,
        .drop_cnt        (drop_cnt),
        .max_outstanding (max_outstanding)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic cancel;
        logic keep;
    } ent_t;

    ent_t q[$];
    bit   m_perr;
    int   m_drops;
    int   m_max;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance model, check registered outputs.
    task automatic step(input bit acc, input bit kp, input bit rok,
                        input bit fh, input bit fs, input bit rst);
        bit   ev, ed, pop, push;
        int   sz;
        ent_t h, e;
        req_accept = acc;
        req_keep   = kp;
        resp_ok    = rok;
        flush_hard = fh;
        flush_soft = fs;
        reset      = rst;
        #2;
        sz  = q.size();
        ev  = 0;
        ed  = 0;
        pop = rok && (sz > 0);
        if (pop && !rst) begin
            h  = q[0];
            ed = h.cancel || fh || (fs && !h.keep);
            ev = !ed;
        end
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        chk("resp_drop", 32'(resp_drop), 32'(ed));
        chk("issue_allow", 32'(issue_allow), 32'((sz < DEPTH) || rok));
        $display("[TB] t=%0t acc=%0b keep=%0b rok=%0b fh=%0b fs=%0b rst=%0b -> valid=%0b drop=%0b occ=%0d",
                 $time, acc, kp, rok, fh, fs, rst, resp_valid, resp_drop, sz);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_perr  = 0;
            m_drops = 0;
            m_max   = 0;
        end else begin
            if (rok && sz == 0) m_perr = 1;
            push = acc && ((sz < DEPTH) || pop);
            if (acc && !push) m_perr = 1;
            if (ed) m_drops++;
            if (pop) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) begin
                e = q[i];
                e.cancel = e.cancel || fh || (fs && !e.keep);
                q[i] = e;
            end
            if (push) q.push_back('{cancel: (fh || (fs && !kp)), keep: kp});
            if (q.size() > m_max) m_max = q.size();
        end
        #1;
        chk("outstanding", 32'(outstanding), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("proto_err", 32'(proto_err), 32'(m_perr));
`ifdef TRACKER_STATS_EN
        chk("drop_cnt", drop_cnt, 32'(m_drops));
        chk("max_outstanding", 32'(max_outstanding), 32'(m_max));
`endif
    endtask

    initial begin
        int drops_seen;
        int valids_seen;
        req_accept = 0; req_keep = 0; resp_ok = 0; flush_hard = 0; flush_soft = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        q.delete(); m_perr = 0; m_drops = 0; m_max = 0;
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_proto_err", 32'(proto_err), 32'd0);
        chk("rst_issue_allow", 32'(issue_allow), 32'd1);

        // Fill, overflow, drain.
        repeat (4) step(1, 0, 0, 0, 0, 0);
        chk("full_occ", 32'(outstanding), 32'd4);
        step(1, 0, 0, 0, 0, 0);
        chk("overflow_err", 32'(proto_err), 32'd1);
        chk("overflow_occ", 32'(outstanding), 32'd4);
        repeat (4) step(0, 0, 1, 0, 0, 0);
        chk("drained_empty", 32'(empty), 32'd1);
        step(0, 0, 0, 0, 0, 1);

        // Soft flush spares the keep-tagged entry.
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 1, 0, 0, 0);
        chk("soft_occ", 32'(outstanding), 32'd0);

        // Hard flush cancels keep-tagged entries too.
        repeat (3) step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        drops_seen = 0; valids_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0, 0);
        end

        // Response colliding with hard flush is dropped; the next one delivers.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);

        // Full with simultaneous push+pop across pointer wrap.
        step(0, 0, 0, 0, 0, 1);
        repeat (4) step(1, 0, 0, 0, 0, 0);
        repeat (10) step(1, 0, 1, 0, 0, 0);
        chk("stream_occ", 32'(outstanding), 32'd4);
        chk("stream_err", 32'(proto_err), 32'd0);

        // Reset discards entries; a later response is a protocol error.
        step(0, 0, 0, 0, 0, 1);
        repeat (2) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        chk("post_rst_err", 32'(proto_err), 32'd1);
        chk("post_rst_occ", 32'(outstanding), 32'd0);
        step(0, 0, 0, 0, 0, 1);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
